// File: rtl/ex_stage_pkg.sv
// Shared ISA and pipeline constants for the execute stage: operand widths,
// ALU/memory/control op codes, exception codes and the EX/MEM register layout.
package ex_stage_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int ALU_OP_W    = 4;
    localparam int MEM_OP_W    = 2;
    localparam int CTRL_OP_W   = 2;
    localparam int EXP_CODE_W  = 3;
    localparam int SHAMT_W     = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_NOP  = 4'd0,
        ALU_OP_AND  = 4'd1,
        ALU_OP_OR   = 4'd2,
        ALU_OP_XOR  = 4'd3,
        ALU_OP_ADDS = 4'd4,
        ALU_OP_ADDU = 4'd5,
        ALU_OP_SUBS = 4'd6,
        ALU_OP_SUBU = 4'd7,
        ALU_OP_SHRL = 4'd8,
        ALU_OP_SHLL = 4'd9
    } alu_op_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2
    } mem_op_e;

    localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = 2'd0;

    typedef enum logic [EXP_CODE_W-1:0] {
        ISA_EXP_NO_EXP   = 3'd0,
        ISA_EXP_EXT_INT  = 3'd1,
        ISA_EXP_OVERFLOW = 3'd3
    } isa_exp_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [MEM_OP_W-1:0]    mem_op;
        logic [WORD_DATA_W-1:0] mem_wr_data;
        logic [CTRL_OP_W-1:0]   ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [EXP_CODE_W-1:0]  exp_code;
        logic [WORD_DATA_W-1:0] out;
    } ex_mem_t;

    // Bubble contents: nothing writes memory or the register file.
    function automatic ex_mem_t ex_mem_bubble();
        ex_mem_t b;
        b.pc          = '0;
        b.en          = 1'b0;
        b.br_flag     = 1'b0;
        b.mem_op      = MEM_OP_NOP;
        b.mem_wr_data = '0;
        b.ctrl_op     = CTRL_OP_NOP;
        b.dst_addr    = '0;
        b.gpr_we_     = 1'b1;
        b.exp_code    = ISA_EXP_NO_EXP;
        b.out         = '0;
        return b;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; flags signed overflow for ADDS/SUBS.
module alu
    import ex_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0]    op,
    input  logic [WORD_DATA_W-1:0] in_0,
    input  logic [WORD_DATA_W-1:0] in_1,
    output logic [WORD_DATA_W-1:0] out,
    output logic                   of
);

    logic [SHAMT_W-1:0] w_sh;
    logic               w_sign_0;
    logic               w_sign_1;
    logic               w_sign_out;

    assign w_sh       = in_1[SHAMT_W-1:0];
    assign w_sign_0   = in_0[WORD_DATA_W-1];
    assign w_sign_1   = in_1[WORD_DATA_W-1];
    assign w_sign_out = out[WORD_DATA_W-1];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        out = '0;
        case (op)
            ALU_OP_NOP:  out = in_0;
            ALU_OP_AND:  out = in_0 & in_1;
            ALU_OP_OR:   out = in_0 | in_1;
            ALU_OP_XOR:  out = in_0 ^ in_1;
            ALU_OP_ADDS,
            ALU_OP_ADDU: out = in_0 + in_1;
            ALU_OP_SUBS,
            ALU_OP_SUBU: out = in_0 - in_1;
            ALU_OP_SHRL: out = in_0 >> w_sh;
            ALU_OP_SHLL: out = in_0 << w_sh;
            default:     out = '0;
        endcase
    end

    always_comb begin
        of = 1'b0;
        case (op)
            ALU_OP_ADDS: of = (w_sign_0 == w_sign_1) && (w_sign_out != w_sign_0);
            ALU_OP_SUBS: of = (w_sign_0 != w_sign_1) && (w_sign_out != w_sign_0);
            default:     of = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU evaluation, exception injection and the EX/MEM register.
// fwd_data exposes the raw ALU result to decode for same-cycle forwarding.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   int_detect,
    input  logic [WORD_ADDR_W-1:0] id_pc,
    input  logic                   id_en,
    input  logic [ALU_OP_W-1:0]    id_alu_op,
    input  logic [WORD_DATA_W-1:0] id_alu_in_0,
    input  logic [WORD_DATA_W-1:0] id_alu_in_1,
    input  logic                   id_br_flag,
    input  logic [MEM_OP_W-1:0]    id_mem_op,
    input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
    input  logic [CTRL_OP_W-1:0]   id_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  id_dst_addr,
    input  logic                   id_gpr_we_,
    input  logic [EXP_CODE_W-1:0]  id_exp_code,
    output logic [WORD_DATA_W-1:0] fwd_data,
    output logic [WORD_ADDR_W-1:0] ex_pc,
    output logic                   ex_en,
    output logic                   ex_br_flag,
    output logic [MEM_OP_W-1:0]    ex_mem_op,
    output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    output logic [CTRL_OP_W-1:0]   ex_ctrl_op,
    output logic [REG_ADDR_W-1:0]  ex_dst_addr,
    output logic                   ex_gpr_we_,
    output logic [EXP_CODE_W-1:0]  ex_exp_code,
    output logic [WORD_DATA_W-1:0] ex_out
);

    logic [WORD_DATA_W-1:0] w_alu_out;
    logic                   w_alu_of;
    ex_mem_t                w_load;
    ex_mem_t                r_ex;

    alu u_alu (
        .op   (id_alu_op),
        .in_0 (id_alu_in_0),
        .in_1 (id_alu_in_1),
        .out  (w_alu_out),
        .of   (w_alu_of)
    );

    assign fwd_data = w_alu_out;

    // An excepting instruction keeps its pc/dst for the handler but must not
    // touch memory or the register file; the interrupt outranks overflow.
    always_comb begin
        w_load.pc          = id_pc;
        w_load.en          = id_en;
        w_load.br_flag     = id_br_flag;
        w_load.mem_op      = id_mem_op;
        w_load.mem_wr_data = id_mem_wr_data;
        w_load.ctrl_op     = id_ctrl_op;
        w_load.dst_addr    = id_dst_addr;
        w_load.gpr_we_     = id_gpr_we_;
        w_load.exp_code    = id_exp_code;
        w_load.out         = w_alu_out;
        if (int_detect) begin
            w_load.mem_op   = MEM_OP_NOP;
            w_load.gpr_we_  = 1'b1;
            w_load.exp_code = ISA_EXP_EXT_INT;
        end else if (w_alu_of) begin
            w_load.mem_op   = MEM_OP_NOP;
            w_load.gpr_we_  = 1'b1;
            w_load.exp_code = ISA_EXP_OVERFLOW;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex <= ex_mem_bubble();
        end else if (stall) begin
            r_ex <= r_ex;
        end else if (flush) begin
            r_ex <= ex_mem_bubble();
        end else begin
            r_ex <= w_load;
        end
    end

    assign ex_pc          = r_ex.pc;
    assign ex_en          = r_ex.en;
    assign ex_br_flag     = r_ex.br_flag;
    assign ex_mem_op      = r_ex.mem_op;
    assign ex_mem_wr_data = r_ex.mem_wr_data;
    assign ex_ctrl_op     = r_ex.ctrl_op;
    assign ex_dst_addr    = r_ex.dst_addr;
    assign ex_gpr_we_     = r_ex.gpr_we_;
    assign ex_exp_code    = r_ex.exp_code;
    assign ex_out         = r_ex.out;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push hand-computed results,
// a negedge monitor pops and compares fwd_data and the EX/MEM register.
module tb_ex_stage;

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        intr;
        logic [29:0] pc;
        logic        en;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic [1:0]  mem;
        logic [31:0] wdata;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exc;
    } vec_t;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  mem;
        logic [31:0] wdata;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exc;
        logic [31:0] out;
    } exp_t;

    typedef struct {
        int    cyc;
        exp_t  e;
        string name;
    } ex_ent_t;

    typedef struct {
        int          cyc;
        logic [31:0] v;
        string       name;
    } fwd_ent_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, int_detect;
    logic [29:0] id_pc;
    logic        id_en;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0, id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    ex_ent_t  ex_q[$];
    fwd_ent_t fwd_q[$];

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .int_detect     (int_detect),
        .id_pc          (id_pc),
        .id_en          (id_en),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_br_flag     (id_br_flag),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_ctrl_op     (id_ctrl_op),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_exp_code    (id_exp_code),
        .fwd_data       (fwd_data),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the scoreboard says is due in this cycle.
    always @(negedge clk) begin
        exp_t act;
        act = {ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
               ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out};
        while (fwd_q.size() > 0 && fwd_q[0].cyc <= cyc) begin
            fwd_ent_t f;
            f = fwd_q.pop_front();
            if (f.cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL %s fwd: expectation for cycle %0d missed", f.name, f.cyc);
            end else begin
                check({f.name, " fwd"}, 128'(fwd_data), 128'(f.v));
            end
        end
        while (ex_q.size() > 0 && ex_q[0].cyc <= cyc) begin
            ex_ent_t x;
            x = ex_q.pop_front();
            if (x.cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL %s ex: expectation for cycle %0d missed", x.name, x.cyc);
            end else begin
                check({x.name, " ex"}, 128'(act), 128'(x.e));
            end
        end
    end

    function automatic exp_t mk(input logic [29:0] pc, input logic en, input logic br,
                                input logic [1:0] mem, input logic [31:0] wdata,
                                input logic [1:0] ctrl, input logic [4:0] dst,
                                input logic we_, input logic [2:0] exc, input logic [31:0] out);
        return {pc, en, br, mem, wdata, ctrl, dst, we_, exc, out};
    endfunction

    // Drive one cycle of inputs (called just after a rising edge) and schedule
    // the forwarding value for now and the EX/MEM contents after the next edge.
    task automatic step(input string name, input vec_t v, input exp_t e, input logic [31:0] fwd);
        reset          = v.rst_n;
        stall          = v.stall;
        flush          = v.flush;
        int_detect     = v.intr;
        id_pc          = v.pc;
        id_en          = v.en;
        id_alu_op      = v.op;
        id_alu_in_0    = v.a;
        id_alu_in_1    = v.b;
        id_br_flag     = v.br;
        id_mem_op      = v.mem;
        id_mem_wr_data = v.wdata;
        id_ctrl_op     = v.ctrl;
        id_dst_addr    = v.dst;
        id_gpr_we_     = v.we_;
        id_exp_code    = v.exc;
        fwd_q.push_back('{cyc, fwd, name});
        ex_q.push_back('{cyc + 1, e, name});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        exp_t clr, ea, eb;
        clr = mk(30'h0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0);
        reset = 1'b0; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        id_pc = '0; id_en = 1'b0; id_alu_op = '0; id_alu_in_0 = '0; id_alu_in_1 = '0;
        id_br_flag = 1'b0; id_mem_op = '0; id_mem_wr_data = '0; id_ctrl_op = '0;
        id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = '0;
        @(posedge clk);
        #1;

        // Reset over two edges with busy inputs (ADDU 5+3).
        v = '{rst_n:1'b0, stall:1'b0, flush:1'b0, intr:1'b0, pc:30'h123, en:1'b1, op:4'd5,
              a:32'd5, b:32'd3, br:1'b1, mem:2'd2, wdata:32'hDEAD, ctrl:2'd2, dst:5'd7,
              we_:1'b0, exc:3'd2};
        step("reset0", v, clr, 32'd8);
        step("reset1", v, clr, 32'd8);

        // ADDS signed overflow, then the same sum unsigned.
        v = '{rst_n:1'b1, stall:1'b0, flush:1'b0, intr:1'b0, pc:30'h10, en:1'b1, op:4'd4,
              a:32'h7FFFFFFF, b:32'h1, br:1'b0, mem:2'd2, wdata:32'h55, ctrl:2'd0, dst:5'd3,
              we_:1'b0, exc:3'd0};
        step("adds_of", v, mk(30'h10, 1, 0, 2'd0, 32'h55, 2'd0, 5'd3, 1, 3'd3, 32'h80000000), 32'h80000000);
        v.op = 4'd5;
        step("addu", v, mk(30'h10, 1, 0, 2'd2, 32'h55, 2'd0, 5'd3, 0, 3'd0, 32'h80000000), 32'h80000000);

        // SUBS overflow at the most negative value, SUBU same operands.
        v.pc = 30'h11; v.op = 4'd6; v.a = 32'h80000000; v.b = 32'h1; v.mem = 2'd1; v.dst = 5'd4;
        step("subs_of", v, mk(30'h11, 1, 0, 2'd0, 32'h55, 2'd0, 5'd4, 1, 3'd3, 32'h7FFFFFFF), 32'h7FFFFFFF);
        v.op = 4'd7;
        step("subu", v, mk(30'h11, 1, 0, 2'd1, 32'h55, 2'd0, 5'd4, 0, 3'd0, 32'h7FFFFFFF), 32'h7FFFFFFF);

        // Signed ops near the sign boundary that must not flag overflow.
        v.op = 4'd4; v.a = 32'hFFFFFFFF; v.b = 32'hFFFFFFFF; v.mem = 2'd0;
        step("adds_noof", v, mk(30'h11, 1, 0, 2'd0, 32'h55, 2'd0, 5'd4, 0, 3'd0, 32'hFFFFFFFE), 32'hFFFFFFFE);
        v.op = 4'd6; v.a = 32'd5; v.b = 32'd7;
        step("subs_noof", v, mk(30'h11, 1, 0, 2'd0, 32'h55, 2'd0, 5'd4, 0, 3'd0, 32'hFFFFFFFE), 32'hFFFFFFFE);

        // Shifts use only the low five bits of in_1; decode exception passes through.
        v.pc = 30'h12; v.op = 4'd8; v.a = 32'hF0000000; v.b = 32'h24; v.dst = 5'd5; v.exc = 3'd2;
        step("shrl", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd2, 32'h0F000000), 32'h0F000000);
        v.op = 4'd9; v.a = 32'h000000FF; v.b = 32'h8; v.exc = 3'd0;
        step("shll", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'h0000FF00), 32'h0000FF00);

        // Bitwise ops, NOP pass-through and an undefined code.
        v.a = 32'hF0F0F0F0; v.b = 32'hFF00FF00;
        v.op = 4'd1;
        step("and", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'hF000F000), 32'hF000F000);
        v.op = 4'd2;
        step("or", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'hFFF0FFF0), 32'hFFF0FFF0);
        v.op = 4'd3;
        step("xor", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'h0FF00FF0), 32'h0FF00FF0);
        v.op = 4'd0;
        step("nop", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'hF0F0F0F0), 32'hF0F0F0F0);
        v.op = 4'd15;
        step("undef", v, mk(30'h12, 1, 0, 2'd0, 32'h55, 2'd0, 5'd5, 0, 3'd0, 32'h0), 32'h0);

        // Load A, then stall three cycles with changing inputs (one with an interrupt).
        v = '{rst_n:1'b1, stall:1'b0, flush:1'b0, intr:1'b0, pc:30'h20, en:1'b1, op:4'd5,
              a:32'h100, b:32'h20, br:1'b1, mem:2'd1, wdata:32'hAAAA, ctrl:2'd1, dst:5'd9,
              we_:1'b0, exc:3'd0};
        ea = mk(30'h20, 1, 1, 2'd1, 32'hAAAA, 2'd1, 5'd9, 0, 3'd0, 32'h120);
        step("load_a", v, ea, 32'h120);
        v.stall = 1'b1; v.pc = 30'h21; v.op = 4'd3; v.a = 32'h1234; v.b = 32'h00FF;
        step("stall0", v, ea, 32'h000012CB);
        v.pc = 30'h22; v.op = 4'd5; v.a = 32'd1; v.b = 32'd2; v.intr = 1'b1;
        step("stall1", v, ea, 32'd3);
        v.pc = 30'h23; v.op = 4'd9; v.a = 32'd1; v.b = 32'd31; v.intr = 1'b0;
        step("stall2", v, ea, 32'h80000000);

        // Flush with valid input gives a bubble; stall+flush holds.
        v.stall = 1'b0; v.flush = 1'b1;
        step("flush", v, clr, 32'h80000000);
        v.flush = 1'b0; v.pc = 30'h30; v.op = 4'd7; v.a = 32'd10; v.b = 32'd4; v.dst = 5'd12;
        eb = mk(30'h30, 1, 1, 2'd1, 32'hAAAA, 2'd1, 5'd12, 0, 3'd0, 32'd6);
        step("load_b", v, eb, 32'd6);
        v.stall = 1'b1; v.flush = 1'b1; v.pc = 30'h31;
        step("stall_flush", v, eb, 32'd6);

        // Interrupt beats overflow; interrupt alone on a normal op.
        v = '{rst_n:1'b1, stall:1'b0, flush:1'b0, intr:1'b1, pc:30'h3FFFFFFF, en:1'b1, op:4'd4,
              a:32'h7FFFFFFF, b:32'h1, br:1'b1, mem:2'd2, wdata:32'h77, ctrl:2'd3, dst:5'd31,
              we_:1'b0, exc:3'd0};
        step("int_of", v, mk(30'h3FFFFFFF, 1, 1, 2'd0, 32'h77, 2'd3, 5'd31, 1, 3'd1, 32'h80000000), 32'h80000000);
        v.op = 4'd5; v.a = 32'd40; v.b = 32'd2; v.pc = 30'h40;
        step("int_only", v, mk(30'h40, 1, 1, 2'd0, 32'h77, 2'd3, 5'd31, 1, 3'd1, 32'd42), 32'd42);

        // Reset asserted mid-stall wins; reload afterwards.
        v.intr = 1'b0; v.stall = 1'b1; v.rst_n = 1'b0;
        step("reset_stall", v, clr, 32'd42);
        v.stall = 1'b0; v.rst_n = 1'b1; v.pc = 30'h41;
        step("reload", v, mk(30'h41, 1, 1, 2'd2, 32'h77, 2'd3, 5'd31, 0, 3'd0, 32'd42), 32'd42);
        v.flush = 1'b1; v.rst_n = 1'b0;
        step("reset_flush", v, clr, 32'd42);

        for (int i = 0; i < 10 && (ex_q.size() > 0 || fwd_q.size() > 0); i++) @(posedge clk);
        if (ex_q.size() > 0 || fwd_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", ex_q.size() + fwd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
